// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM read arbiter.
//   req_valid  per-requester read request
//   req_addr   per-requester address, requester i at [i*AW +: AW]
//   req_ready  one-hot grant (combinational on req_valid)
//   rsp_valid  one-hot, single-cycle response strobe
//   rsp_data   read data shared by all requesters
// master: requester side; slave: arbiter side.
interface rom_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 18,
    parameter int unsigned DW   = 24
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin read arbiter sharing one fixed-latency block ROM between NREQ requesters.
// One read accepted per cycle; each in-flight read carries a one-hot tag through a shift
// register aligned with the ROM pipeline so its data returns to the issuing requester.
//   clk       system clock
//   rst_n     synchronous active-low reset
//   bus       requester bus (slave modport): req_valid/req_addr/req_ready/rsp_valid/rsp_data
//   rom_addr  ROM addra, registered on handshake
//   rom_dout  ROM douta, valid RD_LAT cycles after rom_addr is sampled
module rom_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned AW     = 18,
    parameter int unsigned DW     = 24,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Pointer resets to the last requester so requester 0 is searched first.
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   win_addr;
    int unsigned     idx;

    // An all-zero tag is a bubble, so the one-hot alone doubles as the valid bit.
    logic [RD_LAT:0][NREQ-1:0] tag_q;
    logic [NREQ-1:0]           rsp_valid_q;
    logic [DW-1:0]             rsp_data_q;
    logic [AW-1:0]             rom_addr_q;

    // Search ptr+1 .. ptr+NREQ (mod NREQ); the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(ptr_q) + off) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
        grant = '0;
        if (found) begin
            grant[winner] = 1'b1;
        end
        win_addr = bus.req_addr[32'(winner) * AW +: AW];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= PTR_RST;
            rom_addr_q  <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (found) begin
                ptr_q      <= winner;
                rom_addr_q <= win_addr;
            end
            // Tag stage RD_LAT lines up with rom_dout for the read it describes.
            tag_q       <= {tag_q[RD_LAT-1:0], grant};
            rsp_valid_q <= tag_q[RD_LAT];
            if (|tag_q[RD_LAT]) begin
                rsp_data_q <= rom_dout;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rom_addr      = rom_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
    localparam int unsigned NREQ   = 3;
    localparam int unsigned AW     = 18;
    localparam int unsigned DW     = 24;
    localparam int unsigned RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus1 ();

    logic [AW-1:0] rom_addr, rom_addr1;
    logic [DW-1:0] rom_dout, rom_dout1;
    logic [DW-1:0] rom_pipe [RD_LAT];

    rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .rom_addr (rom_addr1),
        .rom_dout (rom_dout1)
    );

    // ROM contents: a fixed function of the address.
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return {a[5:0] ^ a[17:12], a};
    endfunction

    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(rom_addr);
        for (int k = 1; k < int'(RD_LAT); k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_dout = rom_pipe[RD_LAT-1];
    always @(posedge clk) rom_dout1 <= rom_fn(rom_addr1);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   data;
        int              due;
    } exp_t;
    exp_t sbq[$];

    // Reference model: round-robin by search order from the last grant; each grant pushes
    // the expected response (requester, ROM data, arrival cycle) into the scoreboard.
    initial begin
        int              m_ptr;
        int              w;
        int              idx;
        logic [AW-1:0]   m_addr;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        m_ptr  = NREQ - 1;
        m_addr = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            w = -1;
            for (int k = 1; k <= int'(NREQ); k++) begin
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req_valid[idx]) w = idx;
            end
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("rom_addr", 64'(rom_addr), 64'(m_addr));
            if (!rst_n) begin
                m_ptr  = NREQ - 1;
                m_addr = '0;
            end else if (w >= 0) begin
                m_addr = bus.req_addr[w*AW +: AW];
                e.oh   = exp_rdy;
                e.data = rom_fn(m_addr);
                e.due  = cyc + 2 + int'(RD_LAT);
                sbq.push_back(e);
                m_ptr  = w;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        logic [DW-1:0] last;
        exp_t          e;
        last = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.oh));
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    last = e.data;
                end
            end else begin
                chk("rsp_data_hold", 64'(bus.rsp_data), 64'(last));
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    chk("rsp_missing", 64'(bus.rsp_valid), 64'(e.oh));
                end
            end
            if (!rst_n) begin
                sbq.delete();
                last = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [NREQ-1:0] hs;
        int              n;
        logic            got;

        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus1.req_valid = '0;
        bus1.req_addr  = '0;
        rst_n          = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("reset_rom_addr", 64'(rom_addr), 64'(0));
        step();
        rst_n = 1'b1;

        // All three requesting continuously with distinct addresses.
        bus.req_addr[0*AW +: AW] = 18'h00010;
        bus.req_addr[1*AW +: AW] = 18'h00020;
        bus.req_addr[2*AW +: AW] = 18'h00030;
        bus.req_valid = 3'b111;
        @(negedge clk);
        chk("first_grant_req0", 64'(bus.req_ready), 64'(3'b001));
        for (int k = 0; k < 9; k++) step();
        idle(6);

        // Requester 1 alone, back-to-back.
        for (int k = 0; k < 8; k++) begin
            bus.req_addr[1*AW +: AW] = AW'(k);
            bus.req_valid = 3'b010;
            step();
        end
        idle(2);

        // Last grant was 1: requests from 0 and 2 -> 2 first, then wrap to 0.
        bus.req_addr[0*AW +: AW] = 18'h0aaaa;
        bus.req_addr[2*AW +: AW] = 18'h15555;
        bus.req_valid = 3'b101;
        @(negedge clk);
        chk("wrap_first", 64'(bus.req_ready), 64'(3'b100));
        step();
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("wrap_second", 64'(bus.req_ready), 64'(3'b001));
        step();
        idle(1);

        // Put ptr at 2, then 2 loses to 0 for one cycle and withdraws.
        bus.req_addr[2*AW +: AW] = 18'h00222;
        bus.req_valid = 3'b100;
        step();
        bus.req_addr[0*AW +: AW] = 18'h00111;
        bus.req_addr[2*AW +: AW] = 18'h00333;
        bus.req_valid = 3'b101;
        @(negedge clk);
        chk("withdraw_loser", 64'(bus.req_ready), 64'(3'b001));
        step();
        idle(8);

        // Random traffic: hold until granted, occasional withdrawal.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            step();
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!bus.req_valid[i] || hs[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 3) != 0);
                    bus.req_addr[i*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        idle(8);

        // Three handshakes, then reset before any of them returns.
        for (int k = 0; k < 3; k++) begin
            bus.req_addr[0*AW +: AW] = AW'(18'h00100 + k);
            bus.req_valid = 3'b001;
            step();
        end
        bus.req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("postrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("postrst_rsp_data", 64'(bus.rsp_data), 64'(0));
            chk("postrst_rom_addr", 64'(rom_addr), 64'(0));
            step();
        end
        bus.req_addr[0*AW +: AW] = 18'h3ffff;
        bus.req_addr[1*AW +: AW] = 18'h12345;
        bus.req_addr[2*AW +: AW] = 18'h2fedc;
        bus.req_valid = 3'b111;
        @(negedge clk);
        chk("postrst_ptr", 64'(bus.req_ready), 64'(3'b001));
        step();
        idle(8);

        // RD_LAT=1 instance: single read, response 3 cycles after the handshake.
        bus1.req_addr[2*AW +: AW] = 18'h2abcd;
        bus1.req_valid = 3'b100;
        @(negedge clk);
        n = cyc;
        chk("lat1_ready", 64'(bus1.req_ready), 64'(3'b100));
        step();
        bus1.req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid !== '0) begin
                got = 1'b1;
                chk("lat1_latency", 64'(cyc - n), 64'(3));
                chk("lat1_rsp_valid", 64'(bus1.rsp_valid), 64'(3'b100));
                chk("lat1_rsp_data", 64'(bus1.rsp_data), 64'(rom_fn(18'h2abcd)));
            end
        end
        chk("lat1_rsp_seen", 64'(got), 64'(1));

        idle(4);
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
        $fatal(1);
    end
endmodule
